// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared register map, STATUS layout and TX FSM encoding
package uart_defs;

  // Register select, taken from Addr[3:2] of the rebased offset
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // STATUS bit positions
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_HOLD_BIT = 1;
  localparam int ST_OVR_BIT  = 2;

  // Index of the last data bit in an 8N1 frame
  localparam logic [2:0] LAST_BIT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Pack the three STATUS flags into their bit positions
  function automatic logic [2:0] status_bits(input logic overrun,
                                             input logic hold_full,
                                             input logic shifter_busy);
    logic [2:0] s;
    s              = '0;
    s[ST_OVR_BIT]  = overrun;
    s[ST_HOLD_BIT] = hold_full;
    s[ST_BUSY_BIT] = shifter_busy;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - store/load bus seen by the UART TX peripheral
interface uart_tx_mmio_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  UartEn;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (
    output UartEn,
    output Addr,
    output WriteData,
    input  ReadData
  );

  modport slave (
    input  UartEn,
    input  Addr,
    input  WriteData,
    output ReadData
  );

endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter producing one tick per serial bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  // Next count: clear wins, otherwise count while enabled and wrap at the last cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with 1-byte hold register
module uart_tx_mmio
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_mmio_if.slave     bus,
  output logic              tx,
  output logic              Busy
);

  tx_state_e state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       overrun_q, overrun_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;

  logic       baud_tick;
  logic       hold_take;
  logic       shifter_busy;
  logic [1:0] reg_sel;
  logic       wr_txdata;
  logic       wr_status;
  logic [DATA_WIDTH-1:0] rdata;
  logic       unused_bus_bits;

  assign reg_sel      = bus.Addr[3:2];
  assign wr_txdata    = bus.UartEn && (reg_sel == REG_TXDATA);
  assign wr_status    = bus.UartEn && (reg_sel == REG_STATUS);
  assign shifter_busy = (state_q != ST_IDLE);

  assign tx            = tx_q;
  assign Busy          = shifter_busy || hold_full_q;
  assign bus.ReadData  = rdata;

  // Only Addr[3:2] selects a register and only the low byte carries data
  assign unused_bus_bits = ^{bus.Addr[ADDR_WIDTH-1:4], bus.Addr[1:0],
                             bus.WriteData[DATA_WIDTH-1:8]};

  // The counter idles at zero so every frame starts on a full bit period
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .en_i   (shifter_busy),
    .clr_i  (!shifter_busy),
    .tick_o (baud_tick)
  );

  // Frame sequencer: next state, shifter, bit index and registered line level
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    hold_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          hold_take = 1'b1;
          state_d   = ST_START;
          shift_d   = hold_q;
          bit_d     = '0;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (hold_full_q) begin
            // Chain straight into the next start bit, no idle gap
            hold_take = 1'b1;
            state_d   = ST_START;
            shift_d   = hold_q;
            bit_d     = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Hold register and overrun flag; a write lands if the hold is free or freed this edge
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    if (hold_take) begin
      hold_full_d = 1'b0;
    end
    if (wr_txdata) begin
      if (!hold_full_q || hold_take) begin
        hold_d      = bus.WriteData[7:0];
        hold_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (wr_status && bus.WriteData[ST_OVR_BIT]) begin
      overrun_d = 1'b0;
    end
  end

  // Combinational readback for the load mux
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_TXDATA: rdata[7:0] = hold_q;
      REG_STATUS: rdata[2:0] = status_bits(overrun_q, hold_full_q, shifter_busy);
      default:    rdata      = '0;
    endcase
  end

  // State registers; reset aborts any frame and forces the line high at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for uart_tx_mmio with CLKS_PER_BIT=4
module tb_uart_tx_mmio;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx;
  logic busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb_q[$];

  uart_tx_mmio_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bif ();

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave),
    .tx    (tx),
    .Busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serial monitor: samples each bit mid-period on falling edges
  int         mon_k = -1;
  logic [7:0] mon_byte = '0;
  logic [7:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) mon_k = -1;
      else if (mon_k < 0) begin
        if (tx === 1'b0) mon_k = 0;
      end else mon_k = mon_k + 1;

      if (mon_k == 2) begin
        n_checks++;
        if (tx !== 1'b0) $display("FAIL mon_start_bit got %b exp 0", tx);
        else n_pass++;
      end else if (mon_k >= 6 && mon_k <= 34 && (mon_k % 4) == 2) begin
        mon_byte[(mon_k - 6) / 4] = tx;
      end else if (mon_k == 38) begin
        n_checks++;
        if (tx !== 1'b1) $display("FAIL mon_stop_bit got %b exp 1", tx);
        else n_pass++;
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL mon_unexpected_frame got %02h exp none", mon_byte);
        end else begin
          mon_exp = sb_q.pop_front();
          if (mon_byte !== mon_exp) $display("FAIL mon_frame_byte got %02h exp %02h", mon_byte, mon_exp);
          else n_pass++;
        end
      end else if (mon_k == 39) begin
        mon_k = -1;
      end
    end
  end

  // Bench phase between tasks: 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bif.UartEn    = 1'b1;
    bif.Addr      = a;
    bif.WriteData = d;
    @(posedge clk);
    #1;
    bif.UartEn = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bif.Addr = a;
    #1;
    d = bif.ReadData;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s_idle_timeout got busy=%b exp 0", name, busy);
    else n_pass++;
    tick(2);
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL %s_sb_empty got %0d pending exp 0", name, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bif.UartEn = 1'b0; bif.Addr = '0; bif.WriteData = '0;
    reset = 1'b0;
    tick(3);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL reset_tx got %b exp 1", tx); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    rd(32'h4, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL reset_status got %h exp 0", r); else n_pass++;
    reset = 1'b1;
    tick(2);
    rd(32'h0, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL reset_txdata got %h exp 0", r); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0]  b;
    logic        e;
    logic [31:0] r;
    int          bad;
    b = 8'hA5;
    wr(32'h0, {24'h0, b});
    sb_q.push_back(b);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL single_tx_at_write got %b exp 1", tx); else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy_hold got %b exp 1", busy); else n_pass++;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (c < 4) e = 1'b0;
      else if (c < 36) e = b[(c - 4) / 4];
      else e = 1'b1;
      n_checks++;
      if (tx !== e) $display("FAIL single_wave_c%0d got %b exp %b", c, tx, e);
      else n_pass++;
      if (c == 10) begin
        rd(32'h0, r);
        n_checks++;
        if (r !== 32'h0000_00A5) $display("FAIL single_txdata_rb got %h exp a5", r); else n_pass++;
      end
    end
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_busy_in_stop got %b exp 1", busy); else n_pass++;
    tick(1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_busy_end got %b exp 0", busy); else n_pass++;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL single_tx_end got %b exp 1", tx); else n_pass++;
    tick(3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    wr(32'h0, 32'h55);
    sb_q.push_back(8'h55);
    tick(10);
    wr(32'h0, 32'h0F);
    sb_q.push_back(8'h0F);
    tick(29);
    n_checks++;
    if (tx !== 1'b1) $display("FAIL b2b_stop1 got %b exp 1", tx); else n_pass++;
    tick(1);
    n_checks++;
    if (tx !== 1'b0) $display("FAIL b2b_start2 got %b exp 0", tx); else n_pass++;
    tick(39);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_busy_stop2 got %b exp 1", busy); else n_pass++;
    tick(1);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_busy_80 got %b exp 0", busy); else n_pass++;
    rd(32'h4, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL b2b_status got %h exp 0", r); else n_pass++;
    tick(3);
    wait_idle("b2b", 10);
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    wr(32'h0, 32'h11);
    sb_q.push_back(8'h11);
    wr(32'h0, 32'h22);
    sb_q.push_back(8'h22);
    wr(32'h0, 32'h33);
    rd(32'h4, r);
    n_checks++;
    if (r !== 32'h7) $display("FAIL ovr_status got %h exp 7", r); else n_pass++;
    rd(32'h0, r);
    n_checks++;
    if (r !== 32'h22) $display("FAIL ovr_txdata got %h exp 22", r); else n_pass++;
    wr(32'h4, 32'h0);
    rd(32'h4, r);
    n_checks++;
    if (r[2] !== 1'b1) $display("FAIL ovr_clear0_keeps got %b exp 1", r[2]); else n_pass++;
    wr(32'h4, 32'h4);
    rd(32'h4, r);
    n_checks++;
    if (r !== 32'h3) $display("FAIL ovr_cleared got %h exp 3", r); else n_pass++;
    wait_idle("ovr", 200);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int          lows;
    wr(32'h0, 32'hC3);
    tick(15);
    n_checks++;
    if (tx !== 1'b0) $display("FAIL rst_mid_pre_tx got %b exp 0", tx); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx !== 1'b1) $display("FAIL rst_mid_tx_async got %b exp 1", tx); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else n_pass++;
    rd(32'h4, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL rst_mid_status got %h exp 0", r); else n_pass++;
    tick(1);
    wr(32'h0, 32'h5A);
    reset = 1'b1;
    lows = 0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 0) $display("FAIL rst_mid_quiet got %0d active cycles exp 0", lows); else n_pass++;
  endtask

  task automatic test_decode();
    logic [31:0] r;
    int          lows;
    rd(32'h8, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL dec_rd_8 got %h exp 0", r); else n_pass++;
    rd(32'hC, r);
    n_checks++;
    if (r !== 32'h0) $display("FAIL dec_rd_c got %h exp 0", r); else n_pass++;
    wr(32'h8, 32'hFF);
    lows = 0;
    for (int c = 0; c < 45; c++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    n_checks++;
    if (lows !== 0) $display("FAIL dec_wr_unmapped got %0d active cycles exp 0", lows); else n_pass++;
    wr(32'h1, 32'h3C);
    sb_q.push_back(8'h3C);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL dec_alias_busy got %b exp 1", busy); else n_pass++;
    rd(32'h10, r);
    n_checks++;
    if (r !== 32'h3C) $display("FAIL dec_alias_rb got %h exp 3c", r); else n_pass++;
    rd(32'h5, r);
    n_checks++;
    if (r !== 32'h2) $display("FAIL dec_status_alias got %h exp 2", r); else n_pass++;
    wait_idle("dec", 100);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_decode();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
